axi4_awch_fifo: RTL and testbench
=================================

Name: axi4_awch_fifo

Overview:
- Parametrised, multi-entry write-address (AW) channel buffer for the RAB AXI path; successor to the single-stage AW buffer.
- Generalised in address width and storage depth; adds occupancy and almost-full reporting.
- Sits between the slave-side AW port and the translation/master side.
- Full-throughput FIFO (one push and one pop per cycle) with no combinational ready path from the master side to the slave side.

Parameters:
- C_AXI_ID_WIDTH, 4, AWID width.
- C_AXI_USER_WIDTH, 4, AWUSER width.
- C_AXI_ADDR_WIDTH, 32, AWADDR width.
- C_DEPTH, 4, number of entries; power of two, >= 2.
- C_AFULL_THRESH, C_DEPTH-1, level at or above which almost_full asserts; range 1..C_DEPTH.

Ports:
- axi4_aclk  in  1  clock.
- axi4_arstn  in  1  reset; asynchronous, active-low.
- s_axi4_awid/awaddr/awlen/awsize/awburst/awlock/awprot/awcache/awregion/awqos/awuser  in  ID/ADDR/8/3/2/1/3/4/4/4/USER  slave AW payload.
- s_axi4_awvalid  in  1  slave valid.
- s_axi4_awready  out  1  slave ready.
- m_axi4_awid … m_axi4_awuser  out  same widths as the slave payload  master AW payload.
- m_axi4_awvalid  out  1  master valid.
- m_axi4_awready  in  1  master ready.
- level  out  $clog2(C_DEPTH)+1  current occupancy.
- almost_full  out  1  level >= C_AFULL_THRESH.
- stall_cnt  out  16  present only with AXI4_AWFIFO_STALL_CNT_EN.

Behaviour:
- Storage: circular array of C_DEPTH packed AW beats.
  - Pointers wptr and rptr are each $clog2(C_DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = (wptr == rptr).
  - full = index bits equal and wrap bits differ.
- Push = s_awvalid & s_awready. Pop = m_awvalid & m_awready.
- s_axi4_awready = ~full & init_done.
  - init_done is a register: cleared by reset, set on the first clock edge after reset deassertion.
  - s_awready is therefore 0 during reset and for exactly one cycle after it.
- m_axi4_awvalid = ~empty. m_axi4_awpayload = mem[rptr index]; this is a registered storage read, with no bypass.
- Latency: a beat pushed at edge N is presented on the master side in the cycle after edge N. Minimum latency is 1 cycle. Throughput is 1 beat/cycle.
- AXI stability: while m_awvalid=1 and m_awready=0, the payload and valid stay constant.
- Simultaneous push and pop:
  - Allowed whenever not full.
  - Level is unchanged; both pointers advance.
- Full: s_awready=0 even if m_awready=1 in the same cycle. This avoids the ready path. The push is accepted in the following cycle.
- Empty: m_awvalid=0 and the payload is don't-care. A push into an empty FIFO is visible the next cycle.
- Wrap-around: pointer index wraps from C_DEPTH-1 to 0 and the wrap bit toggles.
- Level:
  - Registered; +1 on push only, -1 on pop only.
  - Always equals the wptr-rptr difference.
  - Range 0..C_DEPTH.
- almost_full is combinational from the registered level.
- Reset (asynchronous, at any time, including mid-burst):
  - Resets wptr, rptr, level, init_done (and stall_cnt when present) to 0.
  - All buffered beats are discarded.
  - Outputs under reset: m_awvalid=0, s_awready=0, level=0, almost_full=0.
  - Storage is not reset.
- Recommended payload bit order, LSB first: cache, prot, lock, burst, size, len, addr, region, qos, id, user.

Optional Feature:
- Macro AXI4_AWFIFO_STALL_CNT_EN.
- Defined:
  - The stall_cnt port exists.
  - A 16-bit counter increments on every cycle with m_awvalid=1 and m_awready=0.
  - It saturates at 16'hFFFF and is cleared only by reset.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Package axi4_rab_pkg holds:
  - field width constants: LEN_W=8, SIZE_W=3, BURST_W=2, PROT_W=3, CACHE_W=4, REGION_W=4, QOS_W=4;
  - a function returning the packed AW beat width from ID/USER/ADDR widths;
  - the aw_beat bit-offset constants.
- One sub-module: axi_fifo_rab. It is a generic DATA_WIDTH/DEPTH FIFO providing valid/ready on both sides plus level.
- The top level packs/unpacks fields, and generates almost_full and the optional stall counter.

Test Plan:
- Single beat, C_DEPTH=4:
  - After reset, stall m_awready=0 and push awaddr=32'h1000_0040, awid=3, awlen=7.
  - Next cycle: m_awvalid=1, fields match, level=1.
  - Payload stays stable for 5 stall cycles.
  - Pop with m_awready=1 → level=0.
- Fill to full: 4 pushes with m_awready=0.
  - s_awready drops after the 4th push; level=4; almost_full=1 from level 3.
  - A 5th attempted beat is held and not lost.
  - Pop once → s_awready=1 next cycle and the 5th beat is accepted.
- Streaming: 64 back-to-back beats with incrementing addr and s_awvalid=m_awready=1 throughout.
  - In-order delivery, 1 beat/cycle after 1-cycle latency.
  - Level steady at 1; pointers wrap 16 times.
- Random valid/ready at 50%, 1000 beats, scoreboard comparison.
  - No loss, duplication or reordering; level always matches the scoreboard count.
- Mid-operation reset: assert axi4_arstn=0 with level=3, asynchronously between edges.
  - Immediately m_awvalid=0, s_awready=0, level=0.
  - s_awready=1 one cycle after release; no stale beats appear.
- With AXI4_AWFIFO_STALL_CNT_EN:
  - Hold a valid beat with m_awready=0 for 10 cycles → stall_cnt=10.
  - Preload near saturation via a long stall → stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/axi4_rab_pkg.sv
// Shared field widths and AW beat bit layout for the RAB AXI path.
package axi4_rab_pkg;

    localparam int LEN_W    = 8;
    localparam int SIZE_W   = 3;
    localparam int BURST_W  = 2;
    localparam int LOCK_W   = 1;
    localparam int PROT_W   = 3;
    localparam int CACHE_W  = 4;
    localparam int REGION_W = 4;
    localparam int QOS_W    = 4;

    // Fixed-width fields sit below the address; the rest depend on ADDR/ID widths.
    localparam int CACHE_LSB = 0;
    localparam int PROT_LSB  = CACHE_LSB + CACHE_W;
    localparam int LOCK_LSB  = PROT_LSB + PROT_W;
    localparam int BURST_LSB = LOCK_LSB + LOCK_W;
    localparam int SIZE_LSB  = BURST_LSB + BURST_W;
    localparam int LEN_LSB   = SIZE_LSB + SIZE_W;
    localparam int ADDR_LSB  = LEN_LSB + LEN_W;

    function automatic int aw_beat_width(input int id_w, input int user_w, input int addr_w);
        return ADDR_LSB + addr_w + REGION_W + QOS_W + id_w + user_w;
    endfunction

endpackage

// File: rtl/axi_fifo_rab.sv
// Generic valid/ready FIFO with wrap-bit pointers, registered occupancy and
// an init_done gate that holds the write side off for one cycle after reset.
module axi_fifo_rab #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic                  init_done;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign empty = (wptr == rptr);
    assign full  = (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]) && (wptr[IDX_W] != rptr[IDX_W]);

    // in_ready depends only on registers, so out_ready never reaches it.
    assign in_ready  = ~full & init_done;
    assign out_valid = ~empty;
    assign out_data  = mem[rptr[IDX_W-1:0]];

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[IDX_W-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            level     <= '0;
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + PTR_W'(1);
                2'b01:   level <= level - PTR_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/axi4_awch_fifo.sv
// Multi-entry AXI4 write-address channel buffer with level and almost_full.
// Optional stall counter enabled by AXI4_AWFIFO_STALL_CNT_EN.
module axi4_awch_fifo
    import axi4_rab_pkg::*;
#(
    parameter int C_AXI_ID_WIDTH   = 4,
    parameter int C_AXI_USER_WIDTH = 4,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_DEPTH          = 4,
    parameter int C_AFULL_THRESH   = C_DEPTH - 1
) (
    input  logic                          axi4_aclk,
    input  logic                          axi4_arstn,

    input  logic [C_AXI_ID_WIDTH-1:0]     s_axi4_awid,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi4_awaddr,
    input  logic [LEN_W-1:0]              s_axi4_awlen,
    input  logic [SIZE_W-1:0]             s_axi4_awsize,
    input  logic [BURST_W-1:0]            s_axi4_awburst,
    input  logic                          s_axi4_awlock,
    input  logic [PROT_W-1:0]             s_axi4_awprot,
    input  logic [CACHE_W-1:0]            s_axi4_awcache,
    input  logic [REGION_W-1:0]           s_axi4_awregion,
    input  logic [QOS_W-1:0]              s_axi4_awqos,
    input  logic [C_AXI_USER_WIDTH-1:0]   s_axi4_awuser,
    input  logic                          s_axi4_awvalid,
    output logic                          s_axi4_awready,

    output logic [C_AXI_ID_WIDTH-1:0]     m_axi4_awid,
    output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi4_awaddr,
    output logic [LEN_W-1:0]              m_axi4_awlen,
    output logic [SIZE_W-1:0]             m_axi4_awsize,
    output logic [BURST_W-1:0]            m_axi4_awburst,
    output logic                          m_axi4_awlock,
    output logic [PROT_W-1:0]             m_axi4_awprot,
    output logic [CACHE_W-1:0]            m_axi4_awcache,
    output logic [REGION_W-1:0]           m_axi4_awregion,
    output logic [QOS_W-1:0]              m_axi4_awqos,
    output logic [C_AXI_USER_WIDTH-1:0]   m_axi4_awuser,
    output logic                          m_axi4_awvalid,
    input  logic                          m_axi4_awready,

    output logic [$clog2(C_DEPTH):0]      level,
    output logic                          almost_full
`ifdef AXI4_AWFIFO_STALL_CNT_EN
    ,
    output logic [15:0]                   stall_cnt
`endif
);

    localparam int BEAT_W     = aw_beat_width(C_AXI_ID_WIDTH, C_AXI_USER_WIDTH, C_AXI_ADDR_WIDTH);
    localparam int REGION_LSB = ADDR_LSB + C_AXI_ADDR_WIDTH;
    localparam int QOS_LSB    = REGION_LSB + REGION_W;
    localparam int ID_LSB     = QOS_LSB + QOS_W;
    localparam int USER_LSB   = ID_LSB + C_AXI_ID_WIDTH;
    localparam int LVL_W      = $clog2(C_DEPTH) + 1;
    localparam logic [LVL_W-1:0] AFULL_T = LVL_W'(C_AFULL_THRESH);

    logic [BEAT_W-1:0] beat_in;
    logic [BEAT_W-1:0] beat_out;

    assign beat_in = {s_axi4_awuser, s_axi4_awid, s_axi4_awqos, s_axi4_awregion,
                      s_axi4_awaddr, s_axi4_awlen, s_axi4_awsize, s_axi4_awburst,
                      s_axi4_awlock, s_axi4_awprot, s_axi4_awcache};

    axi_fifo_rab #(
        .DATA_WIDTH (BEAT_W),
        .DEPTH      (C_DEPTH)
    ) u_fifo (
        .clk       (axi4_aclk),
        .rst_n     (axi4_arstn),
        .in_data   (beat_in),
        .in_valid  (s_axi4_awvalid),
        .in_ready  (s_axi4_awready),
        .out_data  (beat_out),
        .out_valid (m_axi4_awvalid),
        .out_ready (m_axi4_awready),
        .level     (level)
    );

    assign m_axi4_awcache  = beat_out[CACHE_LSB  +: CACHE_W];
    assign m_axi4_awprot   = beat_out[PROT_LSB   +: PROT_W];
    assign m_axi4_awlock   = beat_out[LOCK_LSB];
    assign m_axi4_awburst  = beat_out[BURST_LSB  +: BURST_W];
    assign m_axi4_awsize   = beat_out[SIZE_LSB   +: SIZE_W];
    assign m_axi4_awlen    = beat_out[LEN_LSB    +: LEN_W];
    assign m_axi4_awaddr   = beat_out[ADDR_LSB   +: C_AXI_ADDR_WIDTH];
    assign m_axi4_awregion = beat_out[REGION_LSB +: REGION_W];
    assign m_axi4_awqos    = beat_out[QOS_LSB    +: QOS_W];
    assign m_axi4_awid     = beat_out[ID_LSB     +: C_AXI_ID_WIDTH];
    assign m_axi4_awuser   = beat_out[USER_LSB   +: C_AXI_USER_WIDTH];

    assign almost_full = (level >= AFULL_T);

`ifdef AXI4_AWFIFO_STALL_CNT_EN
    // Counts cycles a beat is offered downstream but not taken; saturating.
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            stall_cnt <= '0;
        end else if (m_axi4_awvalid && !m_axi4_awready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi4_awch_fifo.sv
// Directed and scoreboarded checks of axi4_awch_fifo at C_DEPTH=4.
module tb_axi4_awch_fifo;

    localparam int BW = 69;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic [3:0]  s_awid, m_awid;
    logic [31:0] s_awaddr, m_awaddr;
    logic [7:0]  s_awlen, m_awlen;
    logic [2:0]  s_awsize, m_awsize;
    logic [1:0]  s_awburst, m_awburst;
    logic        s_awlock, m_awlock;
    logic [2:0]  s_awprot, m_awprot;
    logic [3:0]  s_awcache, m_awcache;
    logic [3:0]  s_awregion, m_awregion;
    logic [3:0]  s_awqos, m_awqos;
    logic [3:0]  s_awuser, m_awuser;
    logic        s_awvalid = 1'b0, s_awready;
    logic        m_awvalid, m_awready = 1'b0;
    logic [2:0]  level;
    logic        almost_full;
`ifdef AXI4_AWFIFO_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    axi4_awch_fifo dut (
        .axi4_aclk       (clk),
        .axi4_arstn      (arstn),
        .s_axi4_awid     (s_awid),
        .s_axi4_awaddr   (s_awaddr),
        .s_axi4_awlen    (s_awlen),
        .s_axi4_awsize   (s_awsize),
        .s_axi4_awburst  (s_awburst),
        .s_axi4_awlock   (s_awlock),
        .s_axi4_awprot   (s_awprot),
        .s_axi4_awcache  (s_awcache),
        .s_axi4_awregion (s_awregion),
        .s_axi4_awqos    (s_awqos),
        .s_axi4_awuser   (s_awuser),
        .s_axi4_awvalid  (s_awvalid),
        .s_axi4_awready  (s_awready),
        .m_axi4_awid     (m_awid),
        .m_axi4_awaddr   (m_awaddr),
        .m_axi4_awlen    (m_awlen),
        .m_axi4_awsize   (m_awsize),
        .m_axi4_awburst  (m_awburst),
        .m_axi4_awlock   (m_awlock),
        .m_axi4_awprot   (m_awprot),
        .m_axi4_awcache  (m_awcache),
        .m_axi4_awregion (m_awregion),
        .m_axi4_awqos    (m_awqos),
        .m_axi4_awuser   (m_awuser),
        .m_axi4_awvalid  (m_awvalid),
        .m_axi4_awready  (m_awready),
        .level           (level),
        .almost_full     (almost_full)
`ifdef AXI4_AWFIFO_STALL_CNT_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    logic [BW-1:0] m_beat;
    assign m_beat = {m_awuser, m_awid, m_awqos, m_awregion, m_awaddr, m_awlen,
                     m_awsize, m_awburst, m_awlock, m_awprot, m_awcache};

    // Every field is derived from addr/id/len so one vector checks all of them.
    function automatic logic [BW-1:0] mk(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        return {id ^ 4'h5, id, a[23:20], a[19:16], a, len,
                a[2:0], a[4:3], a[5], a[8:6], a[12:9]};
    endfunction

    task automatic drive(input logic [BW-1:0] b);
        {s_awuser, s_awid, s_awqos, s_awregion, s_awaddr, s_awlen,
         s_awsize, s_awburst, s_awlock, s_awprot, s_awcache} = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        logic [BW-1:0] a_beat;
        logic [BW-1:0] b [5];
        logic [BW-1:0] cur;
        logic [BW-1:0] q [$];
        bit push, pop;
        int sent, rcvd, cyc;

        drive(mk(32'h0, 4'h0, 8'h0));
        repeat (3) step();
        chk("rst_mvalid", m_awvalid, 0);
        chk("rst_sready", s_awready, 0);
        chk("rst_level", level, 0);
        chk("rst_afull", almost_full, 0);
        arstn = 1'b1;
        chk("init_sready0", s_awready, 0);
        step();
        chk("init_sready1", s_awready, 1);

        // single beat with downstream stall
        a_beat = mk(32'h1000_0040, 4'd3, 8'd7);
        drive(a_beat);
        s_awvalid = 1'b1;
        step();
        s_awvalid = 1'b0;
        chk("one_mvalid", m_awvalid, 1);
        chk("one_payload", m_beat, a_beat);
        chk("one_level", level, 1);
        chk("one_afull", almost_full, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("one_hold_valid", m_awvalid, 1);
            chk("one_hold_payload", m_beat, a_beat);
        end
        m_awready = 1'b1;
        step();
        m_awready = 1'b0;
        chk("one_pop_level", level, 0);
        chk("one_pop_mvalid", m_awvalid, 0);

        // fill to full
        for (int i = 0; i < 5; i++) b[i] = mk(32'hA000_0000 + 32'(i * 64), 4'(i + 8), 8'(i + 1));
        for (int i = 0; i < 4; i++) begin
            drive(b[i]);
            s_awvalid = 1'b1;
            chk("fill_sready", s_awready, 1);
            step();
            chk("fill_level", level, BW'(i + 1));
            chk("fill_afull", almost_full, (i + 1 >= 3) ? 1 : 0);
        end
        chk("full_sready", s_awready, 0);
        drive(b[4]);
        repeat (2) step();
        chk("full_hold_sready", s_awready, 0);
        chk("full_hold_level", level, 4);
        chk("full_head", m_beat, b[0]);
        m_awready = 1'b1;
        chk("full_no_ready_path", s_awready, 0);
        step();
        m_awready = 1'b0;
        chk("full_pop_level", level, 3);
        chk("full_pop_sready", s_awready, 1);
        step();
        s_awvalid = 1'b0;
        chk("fifth_level", level, 4);
        m_awready = 1'b1;
        for (int j = 1; j < 5; j++) begin
            chk("drain_valid", m_awvalid, 1);
            chk("drain_payload", m_beat, b[j]);
            step();
        end
        m_awready = 1'b0;
        chk("drain_level", level, 0);
        chk("drain_mvalid", m_awvalid, 0);

        // streaming, one beat per cycle
        m_awready = 1'b1;
        s_awvalid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            cur = mk(32'h2000_0000 + 32'(i * 4), 4'(i), 8'(i * 3));
            drive(cur);
            step();
            chk("stream_payload", m_beat, cur);
            chk("stream_level", level, 1);
        end
        s_awvalid = 1'b0;
        step();
        m_awready = 1'b0;
        chk("stream_end_level", level, 0);

        // random valid/ready against a queue model
        sent = 0;
        rcvd = 0;
        cyc = 0;
        cur = '0;
        while (rcvd < 1000 && cyc < 20000) begin
            cyc++;
            if (!s_awvalid && sent < 1000 && $urandom_range(0, 1) == 1) begin
                cur = mk($urandom, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
                drive(cur);
                s_awvalid = 1'b1;
            end
            m_awready = ($urandom_range(0, 1) == 1);
            chk("rnd_sready", s_awready, (q.size() < 4) ? 1 : 0);
            chk("rnd_mvalid", m_awvalid, (q.size() != 0) ? 1 : 0);
            push = s_awvalid && (q.size() < 4);
            pop  = m_awready && (q.size() != 0);
            if (pop) begin
                chk("rnd_payload", m_beat, q[0]);
                void'(q.pop_front());
                rcvd++;
            end
            if (push) begin
                q.push_back(cur);
                sent++;
            end
            step();
            if (push) s_awvalid = 1'b0;
            chk("rnd_level", level, BW'(q.size()));
        end
        chk("rnd_all_received", BW'(rcvd), 1000);
        s_awvalid = 1'b0;
        m_awready = 1'b0;

        // asynchronous reset with three beats buffered
        for (int i = 0; i < 3; i++) begin
            drive(b[i]);
            s_awvalid = 1'b1;
            step();
        end
        s_awvalid = 1'b0;
        chk("mrst_pre_level", level, 3);
        #3;
        arstn = 1'b0;
        #1;
        chk("mrst_mvalid", m_awvalid, 0);
        chk("mrst_sready", s_awready, 0);
        chk("mrst_level", level, 0);
        chk("mrst_afull", almost_full, 0);
        step();
        arstn = 1'b1;
        chk("mrst_rel_sready0", s_awready, 0);
        step();
        chk("mrst_rel_sready1", s_awready, 1);
        chk("mrst_no_stale", m_awvalid, 0);
        chk("mrst_rel_level", level, 0);
        cur = mk(32'h3000_1230, 4'hC, 8'h0F);
        drive(cur);
        s_awvalid = 1'b1;
        step();
        s_awvalid = 1'b0;
        chk("post_rst_payload", m_beat, cur);
        chk("post_rst_level", level, 1);
        m_awready = 1'b1;
        step();
        m_awready = 1'b0;
        chk("post_rst_empty", level, 0);

`ifdef AXI4_AWFIFO_STALL_CNT_EN
        chk("stall_zero", stall_cnt, 0);
        drive(b[0]);
        s_awvalid = 1'b1;
        step();
        s_awvalid = 1'b0;
        repeat (10) step();
        chk("stall_ten", stall_cnt, 10);
        repeat (65530) step();
        chk("stall_sat", stall_cnt, 16'hFFFF);
        repeat (3) step();
        chk("stall_sat_hold", stall_cnt, 16'hFFFF);
        m_awready = 1'b1;
        step();
        m_awready = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
